// File: rtl/rom_arbiter_pkg.sv
// rom_arbiter_pkg: shared widths, exception codes and FSM encoding for the ROM arbiter
package rom_arbiter_pkg;

    localparam int EXCEPTION_LEN = 4;

    localparam logic [1:0] MEM_WIDTH_BYTE = 2'd0;
    localparam logic [1:0] MEM_WIDTH_HALF = 2'd1;
    localparam logic [1:0] MEM_WIDTH_WORD = 2'd2;

    localparam logic [EXCEPTION_LEN-1:0] EXCEP_OK               = 4'd0;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_INVALID_MEM_READ = 4'd5;
    localparam logic [EXCEPTION_LEN-1:0] EXCEP_MEM_TIMEOUT      = 4'd14;

    typedef enum logic [1:0] {
        ROMARB_IDLE  = 2'd0,
        ROMARB_ISSUE = 2'd1,
        ROMARB_WAIT  = 2'd2,
        ROMARB_RESP  = 2'd3
    } romarb_state_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: combinational two-way round-robin pick; ptr_i=0 favours req[0], 1 favours req[1]
module rr_arbiter_2
    import rom_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o,
    output logic       ptr_next_o
);

    // Grant the single requester, or the favoured one on contention; next pointer favours the loser
    always_comb begin
        gnt_o      = (req_i == 2'b11) ? (ptr_i ? 2'b10 : 2'b01) : req_i;
        ptr_next_o = gnt_o[1] ? 1'b0 : (gnt_o[0] ? 1'b1 : ptr_i);
    end

endmodule

// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one ROM between IF and LS with round-robin grant and completion timeout
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ifReq_In,
    input  logic [31:0]              ifAddr_In,
    input  logic [1:0]               ifWidth_In,
    output logic [31:0]              ifData_Out,
    output logic                     ifDone_Out,
    output logic [EXCEPTION_LEN-1:0] ifException_Out,
    input  logic                     lsReq_In,
    input  logic [31:0]              lsAddr_In,
    input  logic [1:0]               lsWidth_In,
    output logic [31:0]              lsData_Out,
    output logic                     lsDone_Out,
    output logic [EXCEPTION_LEN-1:0] lsException_Out,
    output logic [31:0]              romAddr_Out,
    output logic [1:0]               romWidth_Out,
    output logic                     romValid_Out,
    input  logic [31:0]              romData_In,
    input  logic                     romOK_In,
    input  logic [EXCEPTION_LEN-1:0] romException_In
);

    romarb_state_e            state_q, state_d;
    logic                     ptr_q, ptr_d;
    logic                     nptr_q, nptr_d;
    logic                     owner_q, owner_d;
    logic [31:0]              addr_q, addr_d;
    logic [1:0]               width_q, width_d;
    logic [31:0]              data_q, data_d;
    logic [EXCEPTION_LEN-1:0] exc_q, exc_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     rom_valid_q, rom_valid_d;
    logic                     if_done_q, if_done_d;
    logic                     ls_done_q, ls_done_d;
    logic [31:0]              if_data_q, if_data_d;
    logic [31:0]              ls_data_q, ls_data_d;
    logic [EXCEPTION_LEN-1:0] if_exc_q, if_exc_d;
    logic [EXCEPTION_LEN-1:0] ls_exc_q, ls_exc_d;
    logic [1:0]               gnt;
    logic                     ptr_next;
    logic                     resp_load;

    rr_arbiter_2 u_rr (
        .req_i      ({lsReq_In, ifReq_In}),
        .ptr_i      (ptr_q),
        .gnt_o      (gnt),
        .ptr_next_o (ptr_next)
    );

    // Transaction FSM: capture on grant, one issue cycle, wait for OK or timeout, one response cycle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        nptr_d  = nptr_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        width_d = width_q;
        data_d  = data_q;
        exc_d   = exc_q;
        cnt_d   = cnt_q;
        case (state_q)
            ROMARB_IDLE: begin
                if (|gnt) begin
                    owner_d = gnt[1];
                    addr_d  = gnt[1] ? lsAddr_In : ifAddr_In;
                    width_d = gnt[1] ? lsWidth_In : ifWidth_In;
                    nptr_d  = ptr_next;
                    state_d = ROMARB_ISSUE;
                end
            end
            ROMARB_ISSUE: begin
                exc_d   = romException_In;
                cnt_d   = '0;
                state_d = ROMARB_WAIT;
            end
            ROMARB_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (romOK_In) begin
                    data_d  = romData_In;
                    state_d = ROMARB_RESP;
                end else if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                    data_d  = '0;
                    exc_d   = EXCEP_MEM_TIMEOUT;
                    state_d = ROMARB_RESP;
                end
            end
            ROMARB_RESP: begin
                ptr_d   = nptr_q;
                state_d = ROMARB_IDLE;
            end
            default: state_d = ROMARB_IDLE;
        endcase
    end

    // Output registers are loaded from the next state so every port comes straight from a flop
    always_comb begin
        resp_load   = (state_q == ROMARB_WAIT) && (state_d == ROMARB_RESP);
        rom_valid_d = (state_d == ROMARB_ISSUE);
        if_done_d   = (state_d == ROMARB_RESP) && !owner_q;
        ls_done_d   = (state_d == ROMARB_RESP) && owner_q;
        if_data_d   = (resp_load && !owner_q) ? data_d : if_data_q;
        if_exc_d    = (resp_load && !owner_q) ? exc_d : if_exc_q;
        ls_data_d   = (resp_load && owner_q) ? data_d : ls_data_q;
        ls_exc_d    = (resp_load && owner_q) ? exc_d : ls_exc_q;
    end

    // State and output registers; reset abandons any transaction without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ROMARB_IDLE;
            ptr_q       <= 1'b0;
            nptr_q      <= 1'b0;
            owner_q     <= 1'b0;
            addr_q      <= '0;
            width_q     <= '0;
            data_q      <= '0;
            exc_q       <= EXCEP_OK;
            cnt_q       <= '0;
            rom_valid_q <= 1'b0;
            if_done_q   <= 1'b0;
            ls_done_q   <= 1'b0;
            if_data_q   <= '0;
            ls_data_q   <= '0;
            if_exc_q    <= EXCEP_OK;
            ls_exc_q    <= EXCEP_OK;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            nptr_q      <= nptr_d;
            owner_q     <= owner_d;
            addr_q      <= addr_d;
            width_q     <= width_d;
            data_q      <= data_d;
            exc_q       <= exc_d;
            cnt_q       <= cnt_d;
            rom_valid_q <= rom_valid_d;
            if_done_q   <= if_done_d;
            ls_done_q   <= ls_done_d;
            if_data_q   <= if_data_d;
            ls_data_q   <= ls_data_d;
            if_exc_q    <= if_exc_d;
            ls_exc_q    <= ls_exc_d;
        end
    end

    assign romAddr_Out     = addr_q;
    assign romWidth_Out    = width_q;
    assign romValid_Out    = rom_valid_q;
    assign ifDone_Out      = if_done_q;
    assign lsDone_Out      = ls_done_q;
    assign ifData_Out      = if_data_q;
    assign lsData_Out      = ls_data_q;
    assign ifException_Out = if_exc_q;
    assign lsException_Out = ls_exc_q;

endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single 64 KiB instruction/constant ROM between two requesters: instruction fetch (IF) and load/store unit (LS).
- Grants one transaction at a time with 2-way round-robin and drives the ROM's valid/addr/width inputs.
- Waits for the ROM's 1-cycle-delayed completion and returns data plus exception to the granted requester.
- Sits between the core's fetch/LSU ports and the ROM; adds a completion timeout so a hung ROM cannot stall the core.

Parameters:
TIMEOUT_CYCLES, 16, WAIT-state cycles without romOK_In before the transaction aborts with timeout (min 2)
CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
ifReq_In  in  1  IF request; held with addr/width stable until ifDone_Out
ifAddr_In  in  32  IF byte address
ifWidth_In  in  2  IF access width (MEM_WIDTH_* encoding)
ifData_Out  out  32  IF read data, valid while ifDone_Out
ifDone_Out  out  1  single-cycle IF completion pulse
ifException_Out  out  EXCEPTION_LEN  IF exception code, valid while ifDone_Out
lsReq_In, lsAddr_In, lsWidth_In, lsData_Out, lsDone_Out, lsException_Out: same as IF set, for LS
romAddr_Out  out  32  to ROM addr_In
romWidth_Out  out  2  to ROM dataWidth_In
romValid_Out  out  1  to ROM inputValid_In
romData_In  in  32  from ROM data_Out
romOK_In  in  1  from ROM operationOK_Out
romException_In  in  EXCEPTION_LEN  from ROM exception_Out (combinational, valid while romValid_Out)

Behaviour:
- Reset (rst low, async):
  - State IDLE.
  - All outputs 0; exception outputs `EXCEP_OK.
  - Round-robin pointer = IF-priority.
  - Timeout counter 0; capture registers 0.
  - Reset mid-transaction abandons it; no done pulse is issued.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Neither request: stay.
  - One request: grant it.
  - Both requests: grant the side the pointer favours.
  - On grant: register owner, addr, width; go ISSUE.
- ISSUE (exactly 1 cycle):
  - romValid_Out=1; romAddr_Out/romWidth_Out from capture registers.
  - Latch romException_In into exception register; clear timeout counter; go WAIT.
  - romValid_Out is 0 in every other state.
- WAIT:
  - romOK_In=1: latch romData_In; go RESP.
  - Otherwise increment counter. On reaching TIMEOUT_CYCLES: data register=0, exception register=`EXCEP_MEM_TIMEOUT; go RESP.
- RESP (exactly 1 cycle):
  - Owner's Done_Out=1 with Data_Out and Exception_Out; the other side's Done_Out stays 0.
  - Pointer flips to favour the non-owner; go IDLE.
- Exception precedence:
  - ROM exception latched in ISSUE (e.g. `EXCEP_INVALID_MEM_READ) is still reported after romOK_In.
  - Timeout overrides any latched code.
  - Data is passed through even when the ROM reports an exception.
- Latency: request seen in cycle N gives Done in cycle N+3 with a nominal ROM. Maximum back-to-back rate is one transaction per 4 cycles.
- Requester rules:
  - A requester may drop Req in the Done cycle or hold it for a new request.
  - A held Req is evaluated in IDLE of the next cycle.
  - Req dropped before Done is ignored; the captured transaction completes and Done is still pulsed.
  - Input changes after grant have no effect.
- Fairness: with both requesting continuously, grants alternate IF, LS, IF, LS. Neither side waits more than one foreign transaction.
- Outputs are registered; Data/Exception outputs hold last values outside Done and are not checked by the bench there.
- Spurious romOK_In in IDLE/ISSUE/RESP is ignored.

Decomposition:
- Shared constants in src/constants.v:
  - Add `EXCEP_MEM_TIMEOUT.
  - Add ROM-arbiter state encodings (`ROMARB_IDLE/ISSUE/WAIT/RESP, 2 bits).
  - Reuse existing `MEM_WIDTH_*, `EXCEPTION_LEN, `EXCEP_OK, `EXCEP_INVALID_MEM_READ.
- One sub-module: rr_arbiter_2.
  - Combinational 2-way pick from req[1:0] and pointer.
  - Outputs grant one-hot plus next-pointer; pointer register stays in rom_arbiter.

Test Plan:
1. IF only, ifAddr=0x0000_0100, width word, ROM model returns 0xDEADBEEF with OK one cycle after valid -> romValid_Out high exactly in cycle 1, ifDone_Out in cycle 3, ifData_Out=0xDEADBEEF, ifException_Out=`EXCEP_OK, lsDone_Out never high.
2. IF and LS both request from reset and continuously -> grant order IF, LS, IF, LS; Done pulses every 4 cycles alternating sides; each Done carries its own address's data.
3. LS request to 0x0001_0000 (ROM raises exception) -> lsDone_Out at cycle 3, lsException_Out=`EXCEP_INVALID_MEM_READ, data passed through.
4. ROM model never asserts OK, TIMEOUT_CYCLES=16 -> Done exactly 16 WAIT cycles after ISSUE, Data=0, Exception=`EXCEP_MEM_TIMEOUT; next request then served normally.
5. Pull rst low during WAIT, release 2 cycles later with both Req high -> no Done pulse during or after reset for the aborted transaction, all outputs 0 while low, first new grant goes to IF.
6. Change ifAddr_In from 0x10 to 0x20 in the ISSUE cycle, and separately drop ifReq_In in WAIT -> romAddr_Out stays 0x10; ifDone_Out still pulses once with 0x10's data.
